nrzi_unstuff_rx: RTL

//  USB-style receive front end, successor to the single-bit NRZI decoder. Decodes NRZI line

---
 rtl/usb_rx_pkg.sv | 19 +
 rtl/ones_run_counter.sv | 32 +++
 rtl/nrzi_unstuff_rx.sv | 98 +++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive front end.
// The NRZI decode helper keeps the line-to-bit rule in one place.
package usb_rx_pkg;

  localparam int   USB_STUFF_LEN = 6;
  localparam logic USB_IDLE_J    = 1'b1;
  localparam int   USB_BYTE_W    = 8;

  typedef struct packed {
    logic stuff_err;
    logic align_err;
  } rx_status_t;

  // No line transition decodes as a one; a transition decodes as a zero.
  function automatic logic nrzi_decode(input logic line, input logic prev);
    return ~(line ^ prev);
  endfunction

endpackage

// File: rtl/ones_run_counter.sv
// Counts consecutive decoded ones. at_limit marks the next sample as a stuff slot.
// The count never passes STUFF_LEN because the stuff slot always zeroes it.
module ones_run_counter
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic n_rst,
  input  logic inc,
  input  logic zero,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);

  logic [CNT_W-1:0] ones_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_cnt <= '0;
    end else if (clr || zero) begin
      ones_cnt <= '0;
    end else if (inc) begin
      ones_cnt <= ones_cnt + CNT_W'(1);
    end
  end

  assign at_limit = (ones_cnt == CNT_W'(STUFF_LEN));

endmodule

// File: rtl/nrzi_unstuff_rx.sv
// NRZI decoder with bit unstuffing and LSB-first word assembly.
// All outputs are registered and pulse for one cycle after the qualifying shift.
module nrzi_unstuff_rx
  import usb_rx_pkg::*;
#(
  parameter int   DATA_W    = USB_BYTE_W,
  parameter int   STUFF_LEN = USB_STUFF_LEN,
  parameter logic IDLE_LVL  = USB_IDLE_J
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_plus,
  input  logic              shift_enable,
  input  logic              eop,
  input  logic              clear,
  output logic              d_orig,
  output logic              bit_valid,
  output logic [DATA_W-1:0] rx_word,
  output logic              word_valid,
  output logic              stuff_err,
  output logic              align_err
);

  localparam int BIT_W = $clog2(DATA_W);

  logic              prev;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  rx_status_t        status;

  logic              dec_bit;
  logic              sample;
  logic              end_pkt;
  logic              at_limit;
  logic              word_last;
  logic [DATA_W-1:0] shreg_nxt;

  assign dec_bit   = nrzi_decode(d_plus, prev);
  assign sample    = shift_enable & ~eop & ~clear;
  assign end_pkt   = shift_enable & eop & ~clear;
  assign word_last = (bit_cnt == BIT_W'(DATA_W - 1));
  assign shreg_nxt = {dec_bit, shreg[DATA_W-1:1]};

  // The stuff slot consumes no bit_cnt, so a word never ends on a stuffed bit.
  ones_run_counter #(
    .STUFF_LEN(STUFF_LEN)
  ) u_ones (
    .clk      (clk),
    .n_rst    (n_rst),
    .inc      (sample & ~at_limit & dec_bit),
    .zero     (sample & (at_limit | ~dec_bit)),
    .clr      (clear | end_pkt),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev       <= IDLE_LVL;
      bit_cnt    <= '0;
      shreg      <= '0;
      d_orig     <= 1'b1;
      bit_valid  <= 1'b0;
      rx_word    <= '0;
      word_valid <= 1'b0;
      status     <= '0;
    end else begin
      bit_valid  <= 1'b0;
      word_valid <= 1'b0;
      status     <= '0;
      if (clear || end_pkt) begin
        prev             <= IDLE_LVL;
        bit_cnt          <= '0;
        shreg            <= '0;
        status.align_err <= end_pkt && (bit_cnt != '0);
      end else if (sample) begin
        prev <= d_plus;
        if (at_limit) begin
          status.stuff_err <= dec_bit;
        end else begin
          d_orig    <= dec_bit;
          bit_valid <= 1'b1;
          shreg     <= shreg_nxt;
          if (word_last) begin
            rx_word    <= shreg_nxt;
            word_valid <= 1'b1;
            bit_cnt    <= '0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
      end
    end
  end

  assign stuff_err = status.stuff_err;
  assign align_err = status.align_err;

endmodule
